// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one AXI-stream multiplier between NUM_REQ requesters,
// with an in-order tag FIFO. Optional per-requester grant counters: MUL_ARB_STATS_EN.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [NUM_REQ*DATA_W-1:0]   s_req_a_tdata,
    input  logic [NUM_REQ*DATA_W-1:0]   s_req_b_tdata,
    input  logic [NUM_REQ-1:0]          s_req_tvalid,
    output logic [NUM_REQ-1:0]          s_req_tready,
    output logic [DATA_W-1:0]           m_mul_a_tdata,
    output logic [DATA_W-1:0]           m_mul_b_tdata,
    output logic                        m_mul_tvalid,
    input  logic                        m_mul_tready,
    input  logic [2*DATA_W-1:0]         s_mul_tdata,
    input  logic                        s_mul_tvalid,
    output logic                        s_mul_tready,
    output logic [2*DATA_W-1:0]         m_rsp_tdata,
    output logic [$clog2(NUM_REQ)-1:0]  m_rsp_tid,
    output logic                        m_rsp_tvalid,
    input  logic                        m_rsp_tready,
    output logic                        err_orphan,
    output logic [NUM_REQ*16-1:0]       grant_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW   = $clog2(MAX_OUT) + 1;

    // Every stream transfers on a cycle where tvalid && tready; a source holds
    // its payload stable from tvalid rising until that transfer.
    logic [ID_W-1:0]    ptr;
    logic [CW-1:0]      out_cnt;
    logic [ID_W-1:0]    tag_mem [MAX_OUT];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    logic               slot_free;
    logic               credit;
    logic               prod_acc;
    logic               prod_pop;
    logic               req_acc;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    idx;
    logic               found;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign slot_free    = !m_mul_tvalid || m_mul_tready;
    assign s_mul_tready = !m_rsp_tvalid || m_rsp_tready;
    assign prod_acc     = s_mul_tvalid && s_mul_tready;
    // out_cnt always equals the tag FIFO occupancy, so it doubles as the empty test.
    assign prod_pop     = prod_acc && (out_cnt != '0);
    assign credit       = (out_cnt < CW'(MAX_OUT)) || prod_pop;

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        if (slot_free && credit) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = ptr + ID_W'(k);
                if (!found && s_req_tvalid[idx]) begin
                    found       = 1'b1;
                    gnt_id      = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    assign s_req_tready = arst ? '0 : grant;
    assign req_acc      = |s_req_tready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ptr           <= '0;
            out_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            m_mul_tvalid  <= 1'b0;
            m_mul_a_tdata <= '0;
            m_mul_b_tdata <= '0;
            m_rsp_tvalid  <= 1'b0;
            m_rsp_tdata   <= '0;
            m_rsp_tid     <= '0;
            err_orphan    <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) tag_mem[i] <= '0;
        end else begin
            if (req_acc) begin
                m_mul_tvalid    <= 1'b1;
                m_mul_a_tdata   <= s_req_a_tdata[gnt_id*DATA_W +: DATA_W];
                m_mul_b_tdata   <= s_req_b_tdata[gnt_id*DATA_W +: DATA_W];
                ptr             <= gnt_id + 1'b1;
                tag_mem[wr_ptr] <= gnt_id;
                wr_ptr          <= next_ptr(wr_ptr);
            end else if (slot_free) begin
                m_mul_tvalid <= 1'b0;
            end

            if (prod_pop) rd_ptr <= next_ptr(rd_ptr);

            if (req_acc && !prod_pop)      out_cnt <= out_cnt + 1'b1;
            else if (!req_acc && prod_pop) out_cnt <= out_cnt - 1'b1;

            if (s_mul_tready) begin
                m_rsp_tvalid <= prod_pop;
                if (prod_pop) begin
                    m_rsp_tdata <= s_mul_tdata;
                    m_rsp_tid   <= tag_mem[rd_ptr];
                end
            end

            if (prod_acc && (out_cnt == '0)) err_orphan <= 1'b1;
        end
    end

`ifdef MUL_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s_req_tready[i] && s_req_tvalid[i] && cnt_q[i] != 16'hFFFF)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        assign grant_cnt[gi*16 +: 16] = cnt_q[gi];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed corner cases plus a randomized
// phase against a transaction-level model (grant order, credits, response queue).
module tb_mul_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int M = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic [N*W-1:0]   s_req_a_tdata;
  logic [N*W-1:0]   s_req_b_tdata;
  logic [N-1:0]     s_req_tvalid;
  logic [N-1:0]     s_req_tready;
  logic [W-1:0]     m_mul_a_tdata;
  logic [W-1:0]     m_mul_b_tdata;
  logic             m_mul_tvalid;
  logic             m_mul_tready;
  logic [2*W-1:0]   s_mul_tdata;
  logic             s_mul_tvalid;
  logic             s_mul_tready;
  logic [2*W-1:0]   m_rsp_tdata;
  logic [1:0]       m_rsp_tid;
  logic             m_rsp_tvalid;
  logic             m_rsp_tready;
  logic             err_orphan;
  logic [N*16-1:0]  grant_cnt;

  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  assign s_req_a_tdata = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign s_req_b_tdata = {b_v[3], b_v[2], b_v[1], b_v[0]};

  mul_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_OUT(M)) dut (
    .clk(clk), .arst(arst),
    .s_req_a_tdata(s_req_a_tdata), .s_req_b_tdata(s_req_b_tdata),
    .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
    .m_mul_a_tdata(m_mul_a_tdata), .m_mul_b_tdata(m_mul_b_tdata),
    .m_mul_tvalid(m_mul_tvalid), .m_mul_tready(m_mul_tready),
    .s_mul_tdata(s_mul_tdata), .s_mul_tvalid(s_mul_tvalid), .s_mul_tready(s_mul_tready),
    .m_rsp_tdata(m_rsp_tdata), .m_rsp_tid(m_rsp_tid),
    .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tready(m_rsp_tready),
    .err_orphan(err_orphan), .grant_cnt(grant_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard state
  logic [65:0]  exp_q [$];   // {tid, product} in grant order
  logic [63:0]  op_q  [$];   // {a, b} expected on the multiplier port
  logic [63:0]  pend_q [$];  // products inside the modelled multiplier
  int           m_ptr, m_out, m_cnt [N];
  bit           m_iss_v, m_rsp_v, mul_taken;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    s_req_tvalid = '0;
    m_mul_tready = 1'b1;
    m_rsp_tready = 1'b1;
    s_mul_tvalid = 1'b0;
    s_mul_tdata  = '0;
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    m_ptr = 0; m_out = 0; m_iss_v = 0; m_rsp_v = 0; mul_taken = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    exp_q.delete(); op_q.delete(); pend_q.delete();
  endtask

  // one randomized cycle: drive at negedge, check at +1, model advances for the edge
  task automatic rand_cycle();
    bit     exp_smul, prod_acc, prod_pop, slot, credit;
    int     g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    if (mul_taken) begin
      void'(pend_q.pop_front());
      s_mul_tvalid = 1'b0;
    end
    if (!s_mul_tvalid && pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      s_mul_tvalid = 1'b1;
      s_mul_tdata  = pend_q[0];
    end
    s_req_tvalid = N'($urandom_range(0, 15));
    for (int i = 0; i < N; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
    m_mul_tready = ($urandom_range(0, 3) != 0);
    m_rsp_tready = ($urandom_range(0, 3) != 0);
    #1;
    exp_smul = !m_rsp_v || m_rsp_tready;
    prod_acc = s_mul_tvalid && exp_smul;
    prod_pop = prod_acc && (m_out > 0);
    slot     = !m_iss_v || m_mul_tready;
    credit   = (m_out < M) || prod_pop;
    g = -1;
    if (slot && credit) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && s_req_tvalid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("s_req_tready", 128'(s_req_tready), 128'(exp_rdy));
    check("s_mul_tready", 128'(s_mul_tready), 128'(exp_smul));
    check("m_mul_tvalid", 128'(m_mul_tvalid), 128'(m_iss_v));
    check("m_rsp_tvalid", 128'(m_rsp_tvalid), 128'(m_rsp_v));
    if (m_mul_tvalid && m_mul_tready) begin
      if (op_q.size() == 0) check("issue_without_grant", 128'(1), 128'(0));
      else begin
        check("mul_operands", 128'({m_mul_a_tdata, m_mul_b_tdata}), 128'(op_q[0]));
        pend_q.push_back(64'(op_q[0][63:32]) * 64'(op_q[0][31:0]));
        void'(op_q.pop_front());
      end
    end
    if (m_rsp_tvalid && m_rsp_tready) begin
      if (exp_q.size() == 0) check("rsp_without_grant", 128'(1), 128'(0));
      else check("rsp_tid_data", 128'({m_rsp_tid, m_rsp_tdata}), 128'(exp_q.pop_front()));
    end
    mul_taken = s_mul_tvalid && s_mul_tready;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_cnt[g]++;
      op_q.push_back({a_v[g], b_v[g]});
      exp_q.push_back({2'(g), 64'(a_v[g]) * 64'(b_v[g])});
      m_iss_v = 1;
    end else if (slot) begin
      m_iss_v = 0;
    end
    m_out = m_out + ((g >= 0) ? 1 : 0) - (prod_pop ? 1 : 0);
    if (exp_smul) m_rsp_v = prod_pop;
  endtask

  initial begin
    logic [N*16-1:0] exp_cnt;
    arst = 1'b1;
    idle_inputs();
    s_req_tvalid = '1;
    #1;
    check("rst_s_req_tready", 128'(s_req_tready), 128'(0));
    check("rst_m_mul_tvalid", 128'(m_mul_tvalid), 128'(0));
    check("rst_m_mul_data", 128'({m_mul_a_tdata, m_mul_b_tdata}), 128'(0));
    check("rst_m_rsp", 128'({m_rsp_tvalid, m_rsp_tid, m_rsp_tdata}), 128'(0));
    check("rst_s_mul_tready", 128'(s_mul_tready), 128'(1));
    check("rst_err_orphan", 128'(err_orphan), 128'(0));
    check("rst_grant_cnt", 128'(grant_cnt), 128'(0));

    // credit limit: four grants 0..3, then stall until a product returns
    do_reset();
    s_req_tvalid = '1;
    for (int i = 0; i < M; i++) begin
      #1 check("credit_grant", 128'(s_req_tready), 128'(1 << i));
      @(negedge clk);
    end
    #1 check("credit_exhausted", 128'(s_req_tready), 128'(0));
    s_mul_tvalid = 1'b1;
    s_mul_tdata  = 64'd0;
    #1 check("credit_same_cycle", 128'(s_req_tready), 128'(1));

    // issue stall: ISS holds while multiplier not ready, resumes immediately
    do_reset();
    m_mul_tready = 1'b0;
    s_req_tvalid = 4'b0010;
    a_v[1] = 32'd7; b_v[1] = 32'd9;
    #1 check("stall_first_grant", 128'(s_req_tready), 128'(4'b0010));
    @(negedge clk);
    a_v[1] = 32'd8;
    #1 check("stall_no_grant", 128'(s_req_tready), 128'(0));
    check("stall_iss_hold", 128'({m_mul_tvalid, m_mul_a_tdata, m_mul_b_tdata}), {95'd0, 1'b1, 32'd7, 32'd9});
    m_mul_tready = 1'b1;
    #1 check("stall_resume", 128'(s_req_tready), 128'(4'b0010));

    // max-value product and response backpressure
    do_reset();
    m_rsp_tready = 1'b0;
    s_req_tvalid = 4'b0001;
    a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    s_req_tvalid = '0;
    s_mul_tvalid = 1'b1;
    s_mul_tdata  = 64'(a_v[0]) * 64'(b_v[0]);
    @(negedge clk);
    s_mul_tvalid = 1'b1;
    s_mul_tdata  = 64'd123;
    #1 check("max_rsp", 128'({m_rsp_tvalid, m_rsp_tid, m_rsp_tdata}), {61'd0, 1'b1, 2'd0, 64'hFFFF_FFFE_0000_0001});
    check("bp_s_mul_tready", 128'(s_mul_tready), 128'(0));
    @(negedge clk);
    #1 check("bp_rsp_stable", 128'({m_rsp_tvalid, m_rsp_tdata}), {63'd0, 1'b1, 64'hFFFF_FFFE_0000_0001});
    check("bp_no_orphan", 128'(err_orphan), 128'(0));
    s_mul_tvalid = 1'b0;
    m_rsp_tready = 1'b1;
    @(negedge clk);
    #1 check("bp_drained", 128'(m_rsp_tvalid), 128'(0));

    // orphan product, then reset in the middle of a burst
    do_reset();
    s_mul_tvalid = 1'b1;
    s_mul_tdata  = 64'd55;
    @(negedge clk);
    s_mul_tvalid = 1'b0;
    #1 check("orphan_flag", 128'(err_orphan), 128'(1));
    check("orphan_no_rsp", 128'(m_rsp_tvalid), 128'(0));
    s_req_tvalid = '1;
    a_v[2] = 32'd3; b_v[2] = 32'd5;
    repeat (3) @(negedge clk);
    s_mul_tvalid = 1'b1;
    s_mul_tdata  = 64'd15;
    @(negedge clk);
    #1 check("burst_rsp_tid", 128'({m_rsp_tvalid, m_rsp_tid}), 128'({1'b1, 2'd0}));
    arst = 1'b1;
    #1;
    check("midrst_s_req_tready", 128'(s_req_tready), 128'(0));
    check("midrst_mul", 128'({m_mul_tvalid, m_mul_a_tdata, m_mul_b_tdata}), 128'(0));
    check("midrst_rsp", 128'({m_rsp_tvalid, m_rsp_tid, m_rsp_tdata}), 128'(0));
    check("midrst_flags", 128'({s_mul_tready, err_orphan}), 128'(2'b10));
    check("midrst_grant_cnt", 128'(grant_cnt), 128'(0));

    // randomized traffic against the transaction model
    do_reset();
    for (int c = 0; c < 3000; c++) rand_cycle();
    exp_cnt = '0;
`ifdef MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = 16'(m_cnt[i]);
`endif
    check("rand_grant_cnt", 128'(grant_cnt), 128'(exp_cnt));
    check("rand_no_orphan", 128'(err_orphan), 128'(0));

`ifdef MUL_ARB_STATS_EN
    // counter saturation: products loop back every cycle so credit never runs out
    do_reset();
    s_req_tvalid = 4'b0001;
    s_mul_tvalid = 1'b1;
    s_mul_tdata  = 64'd0;
    repeat (70000) @(negedge clk);
    s_req_tvalid = '0;
    #1 check("sat_grant_cnt", 128'(grant_cnt), 128'({48'd0, 16'hFFFF}));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter that shares one AXI-stream 32x32 Vedic multiplier between NUM_REQ requester streams in the matrix multiplier. Sits between the row/column operand fetch engines and the multiplier. Grants one operand pair per cycle, tracks the requester ID of every in-flight product in an in-order tag FIFO, and returns each product on a single tagged response stream.

## Interface
- NUM_REQ, 4: number of requesters; power of two, 2..8.
- DATA_W, 32: operand width.
- MAX_OUT, 4: maximum in-flight products (issued, not yet returned); power of two.
- clk  in  1  clock; all logic rises on posedge.
- arst  in  1  reset, asynchronous and active-high.
- s_req_a_tdata  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
- s_req_b_tdata  in  NUM_REQ*DATA_W  operand B, same packing.
- s_req_tvalid  in  NUM_REQ  per-requester valid.
- s_req_tready  out  NUM_REQ  per-requester ready; one-hot or zero.
- m_mul_a_tdata  out  DATA_W  operand A to multiplier.
- m_mul_b_tdata  out  DATA_W  operand B to multiplier.
- m_mul_tvalid  out  1  issue valid.
- m_mul_tready  in  1  multiplier accepts.
- s_mul_tdata  in  2*DATA_W  product from multiplier.
- s_mul_tvalid  in  1  product valid.
- s_mul_tready  out  1  arbiter accepts product.
- m_rsp_tdata  out  2*DATA_W  product to requesters.
- m_rsp_tid  out  $clog2(NUM_REQ)  requester that owns the product.
- m_rsp_tvalid  out  1  response valid.
- m_rsp_tready  in  1  response accepted.
- err_orphan  out  1  sticky flag: a product arrived while no tag was outstanding.
- grant_cnt  out  NUM_REQ*16  per-requester accepted-request counters (see Configuration).

## Operation
- Issue register (ISS) holds a, b, valid. Slot free when !m_mul_tvalid or m_mul_tready.
- Outstanding counter OUT counts requests accepted into ISS minus products accepted on s_mul. Credit exists when OUT < MAX_OUT, or a product is accepted in the same cycle.
- Grant: when slot free and credit exists, the first requester with tvalid=1, searching from pointer PTR upward and wrapping modulo NUM_REQ, receives s_req_tready=1. All others see 0. With no valid requester, no ready is asserted.
- On an accepted request from requester g: ISS <= {a_g, b_g}, m_mul_tvalid <= 1, g pushed into tag FIFO (depth MAX_OUT), PTR <= (g+1) mod NUM_REQ, OUT increments.
- Slot free with no grant: m_mul_tvalid <= 0. PTR holds.
- Response register (RSP) is one stage. s_mul_tready = !m_rsp_tvalid or m_rsp_tready.
- On a product handshake with a non-empty tag FIFO: RSP <= {s_mul_tdata, FIFO head}, m_rsp_tvalid <= 1, tag popped, OUT decrements.
- Product handshake with an empty FIFO: product dropped, err_orphan <= 1, OUT unchanged.
- Products are assumed in issue order; the multiplier never reorders.
- Push and pop in the same cycle: OUT and FIFO occupancy unchanged.
- Reset mid-operation discards ISS, RSP, FIFO contents, and in-flight tags. Products arriving after reset raise err_orphan.

## Timing
- Reset values: s_req_tready=0 while arst high; m_mul_tvalid=0, m_mul_a/b_tdata=0; m_rsp_tvalid=0, m_rsp_tdata=0, m_rsp_tid=0; s_mul_tready=1; err_orphan=0; grant_cnt=0; PTR=0; OUT=0.
- Request accept to m_mul_tvalid: 1 cycle.
- Product accept to m_rsp_tvalid: 1 cycle.
- Sustained throughput: 1 grant per cycle while credit and downstream ready hold.
- s_req_tready is combinational from s_req_tvalid, m_mul_tready, OUT, and the product handshake. s_mul_tready is combinational from m_rsp_tready only.
- m_mul_* and m_rsp_* stay stable while valid and not ready (AXI-stream rules).
- err_orphan clears only on reset.

## Configuration
- MUL_ARB_STATS_EN defined: grant_cnt[i*16 +: 16] increments on each accepted request from requester i and saturates at 16'hFFFF.
- MUL_ARB_STATS_EN undefined: grant_cnt is tied to 0 and no counter registers are built.

## Test plan
- Reset, then requesters 0..3 all valid continuously, multiplier and response always ready → grants cycle 0,1,2,3,0. Each m_rsp_tid matches its grant. A=3, B=5 from requester 2 returns m_rsp_tdata=15, tid=2.
- m_mul_tready=0 with requester 1 valid: 1 issue, then s_req_tready stays 0 and ISS holds its value stable. Releasing tready resumes issue the next cycle.
- Multiplier always ready, no products returned, MAX_OUT=4 → exactly 4 grants, then all s_req_tready=0. One product accepted → one new grant in that same cycle.
- m_rsp_tready=0 with a product held in RSP → s_mul_tready=0 and RSP stable. 0xFFFFFFFF×0xFFFFFFFF returns 64'hFFFFFFFE00000001.
- Inject s_mul_tvalid right after reset with no tags → err_orphan=1 and m_rsp_tvalid stays 0. Assert arst mid-burst → all outputs return to reset values immediately.
- With MUL_ARB_STATS_EN: 70000 grants to requester 0 → grant_cnt[15:0]=16'hFFFF. Without the macro: grant_cnt=0.
